// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
// Opcode encoding and flag bit positions live here.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
// The ALU side is the slave; the stage driving operands is the master.
interface alu_if;
  import alu_pkg::*;

  word_t        alu_A;
  word_t        alu_B;
  logic [1:0]   alu_op;
  logic         flag_we;
  word_t        alu;
  logic         zf;
  flags_t       flags_q;

  modport master (
    output alu_A,
    output alu_B,
    output alu_op,
    output flag_we,
    input  alu,
    input  zf,
    input  flags_q
  );

  modport slave (
    input  alu_A,
    input  alu_B,
    input  alu_op,
    input  flag_we,
    output alu,
    output zf,
    output flags_q
  );

endinterface

// File: rtl/alu_addsub.sv
// Shared 16-bit adder/subtractor for ADD and SUB.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module alu_addsub
  import alu_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  sub,
  output word_t sum,
  output logic  cout,
  output logic  ovf
);

  word_t           b_eff;
  logic [DATA_W:0] wide;

  assign b_eff = b ^ {DATA_W{sub}};
  assign wide  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum   = wide[DATA_W-1:0];
  assign cout  = wide[DATA_W];

  // Overflow when both adder inputs agree in sign and the sum does not.
  assign ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
               (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational result and zero flag,
// plus a Z/N/C/V flag register loaded on flag_we.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  alu_op_t op;
  word_t   sum;
  logic    cout;
  logic    ovf;
  logic    is_sub;

  word_t   res;
  logic    c_flag;
  logic    v_flag;
  logic    z_flag;
  logic    n_flag;
  flags_t  flags_d;
  flags_t  flags_r;

  assign op     = alu_op_t'(bus.alu_op);
  assign is_sub = (op == OP_SUB);

  alu_addsub u_addsub (
    .a    (bus.alu_A),
    .b    (bus.alu_B),
    .sub  (is_sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (op)
      OP_ADD,
      OP_SUB: begin
        res    = sum;
        c_flag = cout;
        v_flag = ovf;
      end
      OP_AND: res = bus.alu_A & bus.alu_B;
      OP_OR:  res = bus.alu_A | bus.alu_B;
      default: res = '0;
    endcase
  end

  assign z_flag = (res == '0);
  assign n_flag = res[DATA_W-1];

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = z_flag;
    flags_d[FLAG_N] = n_flag;
    flags_d[FLAG_C] = c_flag;
    flags_d[FLAG_V] = v_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (bus.flag_we) begin
      flags_r <= flags_d;
    end
  end

  assign bus.alu     = res;
  assign bus.zf      = z_flag;
  assign bus.flags_q = flags_r;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU and its flag register.
// Expected values are hand-computed constants.
module tb_alu;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.alu_A   = 16'h1234;
    bus.alu_B   = 16'h1234;
    bus.alu_op  = 2'b01;
    bus.flag_we = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.flags_q !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000", bus.flags_q);
    end
    n_cmp++;
    if (bus.alu !== 16'h0000 || bus.zf !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_comb got %h/%b want 0000/1", bus.alu, bus.zf);
    end
    @(negedge clk);
    bus.flag_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_op_sweep(
    input string             tag,
    input logic [15:0]       a,
    input logic [15:0]       b,
    input logic [0:3][15:0]  exp_res,
    input logic [0:3][3:0]   exp_flg
  );
    for (int op = 0; op < 4; op++) begin
      @(negedge clk);
      bus.alu_A   = a;
      bus.alu_B   = b;
      bus.alu_op  = 2'(op);
      #1;
      n_cmp++;
      if (bus.alu !== exp_res[op] || bus.zf !== exp_flg[op][3]) begin
        n_bad++;
        $display("FAIL %s op%0d result got %h zf=%b want %h zf=%b",
                 tag, op, bus.alu, bus.zf, exp_res[op], exp_flg[op][3]);
      end
      bus.flag_we = 1'b1;
      @(posedge clk);
      #1;
      bus.flag_we = 1'b0;
      n_cmp++;
      if (bus.flags_q !== exp_flg[op]) begin
        n_bad++;
        $display("FAIL %s op%0d flags got %b want %b",
                 tag, op, bus.flags_q, exp_flg[op]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [1:0]  vo [3];
    logic [15:0] vr [3];
    logic [3:0]  vf [3];
    va = '{16'h7FFF, 16'h8000, 16'hFFFF};
    vb = '{16'h0001, 16'h0001, 16'h0001};
    vo = '{2'b00,    2'b01,    2'b00};
    vr = '{16'h8000, 16'h7FFF, 16'h0000};
    vf = '{4'b0101,  4'b0011,  4'b1010};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.alu_A   = va[i];
      bus.alu_B   = vb[i];
      bus.alu_op  = vo[i];
      bus.flag_we = 1'b1;
      #1;
      n_cmp++;
      if (bus.alu !== vr[i]) begin
        n_bad++;
        $display("FAIL ovf%0d result got %h want %h", i, bus.alu, vr[i]);
      end
      @(posedge clk);
      #1;
      bus.flag_we = 1'b0;
      n_cmp++;
      if (bus.flags_q !== vf[i]) begin
        n_bad++;
        $display("FAIL ovf%0d flags got %b want %b", i, bus.flags_q, vf[i]);
      end
    end
  endtask

  task automatic test_flag_reg();
    // Load a nonzero value, then reset mid-cycle.
    @(negedge clk);
    bus.alu_A   = 16'hF234;
    bus.alu_B   = 16'hF234;
    bus.alu_op  = 2'b01;
    bus.flag_we = 1'b1;
    @(posedge clk);
    #1;
    bus.flag_we = 1'b0;
    n_cmp++;
    if (bus.flags_q !== 4'b1010) begin
      n_bad++;
      $display("FAIL preload got %b want 1010", bus.flags_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.flags_q !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_rst got %b want 0000", bus.flags_q);
    end
    // Reset held across an edge with flag_we high.
    bus.flag_we = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.flags_q !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_vs_we got %b want 0000", bus.flags_q);
    end
    @(negedge clk);
    bus.flag_we = 1'b0;
    rst_n = 1'b1;
    bus.alu_A  = 16'h7FFF;
    bus.alu_B  = 16'h0001;
    bus.alu_op = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.flags_q !== 4'b0000) begin
      n_bad++;
      $display("FAIL hold_zero got %b want 0000", bus.flags_q);
    end
    @(negedge clk);
    bus.alu_A   = 16'hF234;
    bus.alu_B   = 16'hF234;
    bus.alu_op  = 2'b01;
    bus.flag_we = 1'b1;
    @(posedge clk);
    #1;
    bus.flag_we = 1'b0;
    n_cmp++;
    if (bus.flags_q !== 4'b1010) begin
      n_bad++;
      $display("FAIL we_pulse got %b want 1010", bus.flags_q);
    end
    @(negedge clk);
    bus.alu_A  = 16'h7FFF;
    bus.alu_B  = 16'h0001;
    bus.alu_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.flags_q !== 4'b1010) begin
      n_bad++;
      $display("FAIL hold_val got %b want 1010", bus.flags_q);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_op_sweep("pos_pos", 16'h0DCA, 16'h0234,
      {16'h0FFE, 16'h0B96, 16'h0000, 16'h0FFE},
      {4'b0000,  4'b0010,  4'b1000,  4'b0000});
    test_op_sweep("neg_pos", 16'hFDCA, 16'h0234,
      {16'hFFFE, 16'hFB96, 16'h0000, 16'hFFFE},
      {4'b0100,  4'b0110,  4'b1000,  4'b0100});
    test_op_sweep("pos_neg", 16'h0DCA, 16'hF234,
      {16'hFFFE, 16'h1B96, 16'h0000, 16'hFFFE},
      {4'b0100,  4'b0000,  4'b1000,  4'b0100});
    test_op_sweep("neg_neg", 16'hF234, 16'hF234,
      {16'hE468, 16'h0000, 16'hF234, 16'hF234},
      {4'b0110,  4'b1010,  4'b0100,  4'b0100});
    test_overflow();
    test_flag_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
